// File: rtl/alu32_nibble_serial_addsub.sv
// Nibble-serial add/subtract: one 4-bit CLA slice per clock, LSB first, with N/Z/C/V flags.
// Optional ALU32_SEQ_CARRYIN_EN adds a carry_in port for ADC/SBC.
module alu32_nibble_serial_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU32_SEQ_CARRYIN_EN
  input  logic             carry_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic             cin0_c;
  logic [3:0]       a_nib_c, b_nib_c, g_c, p_c, sum_c;
  logic             c1_c, c2_c, c3_c, c4_c;
  logic [WIDTH-1:0] shamt_c;

`ifdef ALU32_SEQ_CARRYIN_EN
  assign cin0_c = carry_in;
`else
  assign cin0_c = op_sub;
`endif

  // Current nibble operands and 4-bit carry-lookahead slice
  always_comb begin
    shamt_c = WIDTH'({idx_q, 2'b00});
    a_nib_c = 4'(a_q >> shamt_c);
    b_nib_c = 4'(b_q >> shamt_c);
    g_c     = a_nib_c & b_nib_c;
    p_c     = a_nib_c ^ b_nib_c;
    c1_c    = g_c[0] | (p_c[0] & carry_q);
    c2_c    = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry_q);
    c3_c    = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
            | (p_c[2] & p_c[1] & p_c[0] & carry_q);
    c4_c    = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
            | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
            | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & carry_q);
    sum_c   = p_c ^ {c3_c, c2_c, c1_c, carry_q};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = op_sub ? ~b : b;
          carry_d  = cin0_c;
          idx_d    = '0;
          zero_d   = 1'b1;
          result_d = '0;
          n_d      = 1'b0;
          z_d      = 1'b0;
          c_d      = 1'b0;
          v_d      = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d = (result_q & ~(WIDTH'(4'hF) << shamt_c)) | (WIDTH'(sum_c) << shamt_c);
        carry_d  = c4_c;
        zero_d   = zero_q & (sum_c == 4'h0);
        if (idx_q == IDXW'(NIB - 1)) begin
          c_d     = c4_c;
          v_d     = c3_c ^ c4_c;
          n_d     = sum_c[3];
          z_d     = zero_q & (sum_c == 4'h0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_n = n_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

endmodule

// File: tb/tb_alu32_nibble_serial_addsub.sv
// Randomized bench for alu32_nibble_serial_addsub against a plain-arithmetic reference model.
module tb_alu32_nibble_serial_addsub;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a, b;
`ifdef ALU32_SEQ_CARRYIN_EN
  logic             carry_in;
`endif
  logic             busy, done;
  logic [WIDTH-1:0] result;
  logic             flag_n, flag_z, flag_c, flag_v;

  int checks   = 0;
  int failures = 0;

  alu32_nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
`ifdef ALU32_SEQ_CARRYIN_EN
    .carry_in (carry_in),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_v (flag_v)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One full operation; optionally pulses start mid-run with a different operand.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic sub, input logic cin, input bit disturb);
    logic [WIDTH-1:0] eb, er;
    logic             c0, ec, ev;
    logic [WIDTH:0]   full;
    int               n, busy_cnt;
    eb   = sub ? ~tb_v : tb_v;
`ifdef ALU32_SEQ_CARRYIN_EN
    c0   = cin;
`else
    c0   = sub | (cin & 1'b0);
`endif
    full = {1'b0, ta} + {1'b0, eb} + (WIDTH+1)'(c0);
    er   = full[WIDTH-1:0];
    ec   = full[WIDTH];
    ev   = (ta[WIDTH-1] == eb[WIDTH-1]) && (er[WIDTH-1] != ta[WIDTH-1]);

    @(negedge clk);
    a = ta; b = tb_v; op_sub = sub; start = 1'b1;
`ifdef ALU32_SEQ_CARRYIN_EN
    carry_in = cin;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op_sub = 1'($urandom);
    n = 0;
    busy_cnt = busy ? 1 : 0;
    check_eq("busy_after_accept", 64'(busy), 64'(1));
    while (!done && n < 3 * NIB) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
      start = (disturb && n == 3) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check_eq("latency", 64'(n), 64'(NIB));
    check_eq("busy_cycles", 64'(busy_cnt), 64'(NIB + 1));
    check_eq("result", 64'(result), 64'(er));
    check_eq("flags_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}),
             64'({er[WIDTH-1], (er == '0), ec, ev}));
    @(posedge clk); #1;
    check_eq("done_one_cycle", 64'({busy, done}), 64'(0));
    check_eq("result_hold", 64'(result), 64'(er));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
`ifdef ALU32_SEQ_CARRYIN_EN
    carry_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", 64'({busy, done, flag_n, flag_z, flag_c, flag_v}), 64'(0));
    check_eq("reset_result", 64'(result), 64'(0));
    @(negedge clk); reset = 1'b0;

    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
`ifdef ALU32_SEQ_CARRYIN_EN
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    run_op(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic sub, cin;
      sub = 1'($urandom);
      cin = 1'($urandom);
`ifndef ALU32_SEQ_CARRYIN_EN
      cin = sub;
`endif
      run_op(WIDTH'($urandom), WIDTH'($urandom), sub, cin, bit'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a run
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; op_sub = 1'b0; start = 1'b1;
`ifdef ALU32_SEQ_CARRYIN_EN
    carry_in = 1'b0;
`endif
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("partial_before_reset", 64'(result != '0), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_mid_ctrl", 64'({busy, done, flag_n, flag_z, flag_c, flag_v}), 64'(0));
    check_eq("reset_mid_result", 64'(result), 64'(0));
    @(negedge clk); reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 2 * NIB + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check_eq("no_done_after_reset", 64'(dcnt), 64'(0));

    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu32_nibble_serial_addsub.md
Name: alu32_nibble_serial_addsub

Overview:
Multi-cycle 32-bit add/subtract unit built around a single 4-bit carry-lookahead slice with overflow tap. Operands are processed one nibble per clock, LSB first, with the slice's carry-out fed back through a register. The unit produces a full-width result plus N/Z/C/V flags. It is the area-reduced alternative to the parallel 8-slice ALU adder and feeds the ALU result/flag mux.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4 and at least 8
NIB, WIDTH/4, derived nibble count (8 by default); not user-set

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = a+b, 1 = a-b; latched with start
a  input  WIDTH  operand A; latched with start
b  input  WIDTH  operand B; latched with start
busy  output  1  high while state is RUN or DONE
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  sum/difference
flag_n  output  1  result[WIDTH-1]
flag_z  output  1  result == 0
flag_c  output  1  carry-out of MSB nibble (sub: 1 = no borrow)
flag_v  output  1  signed overflow = c3 XOR co of MSB nibble

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-high.
- Reset state: FSM in IDLE, nibble index 0, carry register 0. Outputs busy, done, result, and all four flags = 0.
- Reset mid-operation aborts the operation. Partial result is discarded and outputs return to reset values on the next edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b, op_sub.
  - Latch operand B as b when op_sub=0, and as ~b when op_sub=1.
  - Carry register <= op_sub (carry-in 0 for add, 1 for sub).
  - Index <= 0; result and flags cleared to 0; go to RUN.
- RUN: each edge computes nibble[idx] = A_nib + B_nib + carry_reg using a 4-bit CLA slice.
  - result[4*idx+3:4*idx] <= slice sum.
  - carry_reg <= slice co.
  - Zero tracker ANDs in (slice sum == 0).
  - When idx = NIB-1: flag_c <= co, flag_v <= c3 ^ co, flag_n <= sum[3], flag_z <= tracker AND (sum == 0); go to DONE.
  - Otherwise idx <= idx+1.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: start accepted at edge k; done high during the cycle after edge k+NIB (k+8 by default).
- Throughput: one operation per NIB+2 cycles.
- busy=1 in RUN and DONE. start is ignored while busy; there is no queuing.
- result and flags hold their last values in IDLE until the next accepted start, which clears them.
- Input stability: a, b, op_sub are sampled only at the accepting edge. Changes afterwards have no effect.
- Arithmetic is modulo 2^WIDTH. flag_c for sub follows the ARM convention (C=1 means a >= b unsigned).

Optional Feature:
Macro: ALU32_SEQ_CARRYIN_EN
- Defined:
  - Adds input port carry_in (1 bit), latched with start.
  - Initial carry register <= carry_in for both ops, giving ADC (a+b+cin) and SBC (a+~b+cin).
  - op_sub still inverts b.
- Undefined: port is absent; initial carry = op_sub.

Test Plan:
- Add, no overflow: a=0x0000_0001, b=0x0000_0002, op_sub=0 → result 0x0000_0003, N=0 Z=0 C=0 V=0. done exactly 8 cycles after accept; busy high 9 cycles.
- Carry ripple across all nibbles: a=0xFFFF_FFFF, b=0x0000_0001 add → result 0x0000_0000, Z=1 C=1 V=0 N=0.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001 add → result 0x8000_0000, N=1 V=1 C=0. Then sub a=0x8000_0000, b=0x0000_0001 → result 0x7FFF_FFFF, V=1 C=1 N=0.
- Borrow: sub a=0x0000_0003, b=0x0000_0005 → result 0xFFFF_FFFE, N=1 C=0 V=0. Sub with a=b=0x1234_5678 → result 0, Z=1 C=1.
- Start while busy / reset mid-op: assert start with a new operand at RUN cycle 3 → ignored, first result is unaffected. Assert reset at RUN cycle 4 → next cycle busy=0, done=0, result=0, flags=0; no done pulse follows.
- With ALU32_SEQ_CARRYIN_EN: a=0x0000_0001, b=0x0000_0001, carry_in=1, add → 0x0000_0003. Same with op_sub=1, carry_in=0 → 0xFFFF_FFFF, C=0.
